// File: rtl/hyperram_lb_pkg.sv
// hyperram_lb_pkg: shared constants and state encoding for the HyperRAM local-bus master.
package hyperram_lb_pkg;
    localparam logic [31:0] CMD_WR = 32'h0000_0001;
    localparam logic [31:0] CMD_RD = 32'h0000_0002;
    localparam int REG_CMD  = 0;
    localparam int REG_ADDR = 1;
    localparam int REG_DATA = 2;
    localparam int REG_STAT = 3;
    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, WR_CMD, WR_WAIT,
        RD_ADDR, RD_CMD, RD_REQ, RD_WAIT, ACK, ERR
    } lb_state_t;
endpackage

// File: rtl/hyperram_lb_master.sv
// hyperram_lb_master: Wishbone classic responder that turns single 32-bit accesses
// into address/data/command register writes on the hyper_dword local bus.
module hyperram_lb_master
    import hyperram_lb_pkg::*;
#(
    parameter int AW         = 24,
    parameter int WR_HOLDOFF = 32,
    parameter int RD_TIMEOUT = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [31:0]   wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    output logic [31:0]   wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          lb_cs_reg0,
    output logic          lb_cs_reg1,
    output logic          lb_cs_reg2,
    output logic          lb_cs_reg3,
    output logic          lb_wr,
    output logic          lb_rd,
    output logic [31:0]   lb_wr_d,
    input  logic [31:0]   lb_rd_d,
    input  logic          lb_rd_rdy
);
    localparam int CW = $clog2(WR_HOLDOFF > RD_TIMEOUT ? WR_HOLDOFF : RD_TIMEOUT) + 1;

    lb_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-3:0] adr_q, adr_d;
    logic [31:0]   wdat_q, wdat_d, rdat_q, rdat_d, wd_q, wd_d;
    logic [3:0]    cs_q, cs_d;
    logic          abort_q, abort_d, ack_q, ack_d, err_q, err_d, wr_q, wr_d, rd_q, rd_d;
    logic          aborted, is_addr, is_cmd, is_data;
    logic          unused_adr;

    assign unused_adr = &{1'b0, wb_adr_i[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        // A dropped cycle only suppresses the termination; the local bus always finishes.
        aborted = abort_q | ~wb_cyc_i;
        case (state_q)
            IDLE: if (wb_cyc_i && wb_stb_i) begin
                adr_d   = wb_adr_i[AW-1:2];
                wdat_d  = wb_dat_i;
                state_d = wb_sel_i != 4'hF ? ERR : wb_we_i ? WR_ADDR : RD_ADDR;
            end
            WR_ADDR: state_d = WR_DATA;
            WR_DATA: state_d = WR_CMD;
            WR_CMD: begin
                state_d = WR_WAIT;
                cnt_d   = CW'(WR_HOLDOFF - 1);
            end
            WR_WAIT: begin
                state_d = cnt_q == '0 ? ACK : WR_WAIT;
                cnt_d   = cnt_q - CW'(1);
            end
            RD_ADDR: state_d = RD_CMD;
            RD_CMD: begin
                state_d = RD_REQ;
                cnt_d   = CW'(RD_TIMEOUT - 1);
            end
            RD_REQ, RD_WAIT: begin
                state_d = lb_rd_rdy ? ACK : cnt_q == '0 ? ERR : RD_WAIT;
                rdat_d  = lb_rd_rdy ? lb_rd_d : rdat_q;
                cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase
        abort_d = state_q != IDLE && aborted;
        rdat_d  = state_d == ERR ? '0 : rdat_d;
        ack_d   = state_d == ACK && !aborted;
        err_d   = state_d == ERR && !aborted;
        is_addr = state_d == WR_ADDR || state_d == RD_ADDR;
        is_cmd  = state_d == WR_CMD || state_d == RD_CMD;
        is_data = state_d == WR_DATA || state_d == RD_REQ;
        cs_d    = (4'(is_cmd) << REG_CMD) | (4'(is_addr) << REG_ADDR) | (4'(is_data) << REG_DATA);
        wr_d    = is_addr || is_cmd || state_d == WR_DATA;
        rd_d    = state_d == RD_REQ;
        wd_d    = is_addr ? 32'(adr_d) : state_d == WR_DATA ? wdat_q :
                  state_d == WR_CMD ? CMD_WR : state_d == RD_CMD ? CMD_RD : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            wd_q    <= '0;
            cs_q    <= '0;
            abort_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            wd_q    <= wd_d;
            cs_q    <= cs_d;
            abort_q <= abort_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    assign wb_dat_o   = rdat_q;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign lb_cs_reg0 = cs_q[REG_CMD];
    assign lb_cs_reg1 = cs_q[REG_ADDR];
    assign lb_cs_reg2 = cs_q[REG_DATA];
    assign lb_cs_reg3 = cs_q[REG_STAT];
    assign lb_wr      = wr_q;
    assign lb_rd      = rd_q;
    assign lb_wr_d    = wd_q;
endmodule

// File: doc/hyperram_lb_master.md
# hyperram_lb_master

Wishbone B4 classic (non-pipelined) responder that turns single 32-bit CPU/DMA accesses into the local-bus register sequence driven into `hyper_dword`. It sits inside the HyperRAM Wishbone wrapper, on the system side of the local bus. Per access it writes the address register, the data register (writes only) and the command register. It then waits for completion and returns ack, data or error to the Wishbone initiator.

## Interface
Parameters:
- `AW`, 24: Wishbone byte-address width; HyperRAM dword address = `wb_adr_i[AW-1:2]`.
- `WR_HOLDOFF`, 32: cycles waited after the write command before ack (≥1).
- `RD_TIMEOUT`, 256: maximum cycles waited for `lb_rd_rdy` before error (≥1).

Ports:
- `clk`  in  1  sole clock; the local bus runs on it (`clk_lb` of `hyper_dword` = `clk`).
- `reset`  in  1  asynchronous, active-high.
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i`  in  1 each  Wishbone cycle, strobe, write enable.
- `wb_adr_i`  in  AW  byte address.
- `wb_dat_i`  in  32  write data.
- `wb_sel_i`  in  4  byte selects; only 4'hF is legal.
- `wb_dat_o`  out  32  read data, valid with `wb_ack_o`.
- `wb_ack_o`, `wb_err_o`  out  1 each  single-cycle termination.
- `lb_cs_reg0`..`lb_cs_reg3`  out  1 each  register selects: 0 = command, 1 = address, 2 = data, 3 = status (unused).
- `lb_wr`, `lb_rd`  out  1 each  one-cycle local-bus strobes.
- `lb_wr_d`  out  32  local-bus write data.
- `lb_rd_d`  in  32  local-bus read data.
- `lb_rd_rdy`  in  1  read data valid.

## Operation
- All outputs are registered. All outputs reset to 0. The FSM resets to IDLE.
- Each local-bus write is one cycle: `lb_wr` = 1, exactly one `lb_cs_regN` = 1, and `lb_wr_d` carries the value. Outside such cycles, selects, strobes and `lb_wr_d` are 0.
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_CMD, WR_WAIT, RD_ADDR, RD_CMD, RD_REQ, RD_WAIT, ACK, ERR.
- IDLE:
  - Waits for `wb_cyc_i & wb_stb_i`.
  - `wb_sel_i` ≠ 4'hF → ERR, with no local-bus activity.
  - Otherwise, `wb_we_i` → WR_ADDR, else RD_ADDR.
  - Address, data and direction are latched on this edge.
- Write path:
  - WR_ADDR: reg1 ← zero-extended dword address.
  - WR_DATA: reg2 ← data.
  - WR_CMD: reg0 ← `CMD_WR` (32'h0000_0001).
  - WR_WAIT: counts `WR_HOLDOFF` cycles, then → ACK.
- Read path:
  - RD_ADDR: reg1 ← address.
  - RD_CMD: reg0 ← `CMD_RD` (32'h0000_0002).
  - RD_REQ: `lb_rd` = 1 with `lb_cs_reg2` = 1 for one cycle, then → RD_WAIT.
  - `lb_rd_rdy` is sampled from RD_REQ onward. The first `lb_rd_rdy` captures `lb_rd_d` into `wb_dat_o` → ACK.
  - If no ready arrives within `RD_TIMEOUT` cycles counted from RD_REQ → ERR.
- ACK: `wb_ack_o` = 1 for one cycle → IDLE. ERR: `wb_err_o` = 1 for one cycle → IDLE.
- `wb_dat_o` holds its last captured value; it is 0 after error.
- `lb_rd_rdy` outside RD_REQ/RD_WAIT is ignored.
- Abort: if `wb_cyc_i` drops mid-sequence, the local-bus sequence still runs to completion (`hyper_dword` cannot be aborted). The final ACK/ERR cycle is suppressed (no ack/err output) and the FSM returns to IDLE.
- `wb_ack_o` and `wb_err_o` are never asserted together.
- `wb_stb_i` is ignored while not in IDLE.

## Timing
- Cycle N = IDLE cycle in which the strobe is sampled.
- Write:
  - `lb_wr` on N+1 (reg1), N+2 (reg2), N+3 (reg0).
  - `wb_ack_o` at N+4+`WR_HOLDOFF`.
  - Total latency `WR_HOLDOFF`+4 cycles.
- Read:
  - `lb_wr` on N+1 (reg1) and N+2 (reg0); `lb_rd` on N+3.
  - Ready first seen at cycle M ≥ N+3 → `wb_ack_o` and `wb_dat_o` at M+1.
  - No ready through N+2+`RD_TIMEOUT` → `wb_err_o` at N+3+`RD_TIMEOUT`.
- Bad `wb_sel_i`: `wb_err_o` at N+1.
- Back-to-back: the next strobe can be accepted in the cycle after ACK/ERR. The initiator must drop `wb_stb_i` on ack per classic rules.
- Reset asserted mid-sequence: all outputs 0 immediately (asynchronous); the FSM returns to IDLE and no termination is issued.

## Structure
- Package `hyperram_lb_pkg`:
  - `CMD_WR`, `CMD_RD`.
  - Register index constants `REG_CMD`=0, `REG_ADDR`=1, `REG_DATA`=2, `REG_STAT`=3.
  - State enum `lb_state_t`.
- One shared down-counter inside the module serves both `WR_HOLDOFF` and `RD_TIMEOUT`. Its width is `$clog2` of the larger of the two, +1.
- No sub-module; the block is a single FSM plus datapath registers.

## Test plan
- Write 0x1234_5678 to byte address 0x00_0040, `WR_HOLDOFF`=4:
  - reg1 = 0x10, reg2 = 0x1234_5678, reg0 = 0x1 on consecutive cycles.
  - Ack at N+8.
- Read 0x00_0040 with `lb_rd_rdy` pulsed 5 cycles after `lb_rd` and `lb_rd_d`=0xCAFE_F00D:
  - reg1 = 0x10, reg0 = 0x2.
  - Ack one cycle after ready, `wb_dat_o`=0xCAFE_F00D.
- Read with no `lb_rd_rdy`, `RD_TIMEOUT`=16: `wb_err_o` at N+19; no ack; FSM back in IDLE.
- `wb_sel_i`=4'h3 write: `wb_err_o` at N+1; `lb_wr` never asserted.
- `wb_cyc_i` dropped at N+2 of a write: reg0 command still issued; no ack/err; next access completes normally.
- Reset asserted during RD_WAIT, then a fresh read: all outputs 0 during reset; a stale `lb_rd_rdy` after reset is ignored; the new read returns correct data.
